// File: rtl/rnd_lfsr_source.sv
// rnd_lfsr_source: seeded pseudo-random block source built on a 128-bit Fibonacci LFSR.
// The source is seeded by four 32-bit beats, runs a discarded warm-up, and then
// presents one RND_W-bit block per accepted transfer. A block is never shown
// again after it has been consumed.
//
// Handshakes: both interfaces use valid/ready. A seed beat transfers on a rising
// edge where seed_valid && seed_ready. A random block transfers on a rising edge
// where rnd_valid && rnd_ready. rnd_out is meaningful only while rnd_valid is
// high, and it holds steady while rnd_valid is high and rnd_ready is low.
module rnd_lfsr_source #(
    parameter int RND_W  = 8,
    parameter int WARMUP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    output logic [RND_W-1:0] rnd_out,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             seeded,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [7:0] WARM_N = 8'(WARMUP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [127:0]     r_s;
    logic [127:0]     w_s_nxt;
    logic [127:0]     w_step_s;
    logic [127:0]     w_loaded;
    logic [1:0]       r_beat;
    logic [1:0]       w_beat_nxt;
    logic [7:0]       r_warm;
    logic [7:0]       w_warm_nxt;
    logic [RND_W-1:0] r_rnd_out;
    logic [RND_W-1:0] w_rnd_out_nxt;
    logic [RND_W-1:0] w_block;
    logic             r_rnd_valid;
    logic             w_rnd_valid_nxt;
    logic             r_seeded;
    logic             w_seeded_nxt;
    logic             w_seed_acc;

    // Seeds are refused only while the warm-up run is in progress.
    assign seed_ready = (r_state != ST_WARMUP);
    assign w_seed_acc = seed_valid && seed_ready;

    assign rnd_out   = r_rnd_out;
    assign rnd_valid = r_rnd_valid;
    assign seeded    = r_seeded;
    assign dbg_state = r_state;

    // One block step: RND_W single LFSR steps unrolled; the first feedback bit lands in bit 0.
    always_comb begin
        w_step_s = r_s;
        w_block  = '0;
        for (int i = 0; i < RND_W; i++) begin
            w_block[i] = w_step_s[127] ^ w_step_s[125] ^ w_step_s[100] ^ w_step_s[98];
            w_step_s   = {w_step_s[126:0], w_block[i]};
        end
    end

    // Next-state and datapath decisions for every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_beat_nxt      = r_beat;
        w_warm_nxt      = r_warm;
        w_rnd_out_nxt   = r_rnd_out;
        w_rnd_valid_nxt = r_rnd_valid;
        w_seeded_nxt    = r_seeded;
        w_loaded        = {seed_in, r_s[95:0]};
        case (r_state)
            ST_IDLE: begin
                if (w_seed_acc) begin
                    w_s_nxt[31:0] = seed_in;
                    w_beat_nxt    = 2'd1;
                    w_state_nxt   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_seed_acc) begin
                    if (r_beat == 2'd3) begin
                        // An all-zero state would lock the LFSR; substitute the smallest nonzero state.
                        w_s_nxt     = (w_loaded == '0) ? 128'd1 : w_loaded;
                        w_warm_nxt  = 8'd0;
                        w_state_nxt = ST_WARMUP;
                    end else begin
                        w_s_nxt[{r_beat, 5'd0} +: 32] = seed_in;
                        w_beat_nxt                    = r_beat + 2'd1;
                    end
                end
            end
            ST_WARMUP: begin
                w_s_nxt = w_step_s;
                if (r_warm != WARM_N) begin
                    w_warm_nxt = r_warm + 8'd1;
                end else begin
                    w_rnd_out_nxt   = w_block;
                    w_rnd_valid_nxt = 1'b1;
                    w_seeded_nxt    = 1'b1;
                    w_state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_seed_acc) begin
                    // Reseed: a same-cycle rnd_ready still counts as consuming the current block.
                    w_s_nxt[31:0]   = seed_in;
                    w_beat_nxt      = 2'd1;
                    w_rnd_valid_nxt = 1'b0;
                    w_seeded_nxt    = 1'b0;
                    w_state_nxt     = ST_LOAD;
                end else if (r_rnd_valid && rnd_ready) begin
                    w_s_nxt       = w_step_s;
                    w_rnd_out_nxt = w_block;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LFSR, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= '0;
            r_beat      <= 2'd0;
            r_warm      <= 8'd0;
            r_rnd_out   <= '0;
            r_rnd_valid <= 1'b0;
            r_seeded    <= 1'b0;
        end else begin
            r_s         <= w_s_nxt;
            r_beat      <= w_beat_nxt;
            r_warm      <= w_warm_nxt;
            r_rnd_out   <= w_rnd_out_nxt;
            r_rnd_valid <= w_rnd_valid_nxt;
            r_seeded    <= w_seeded_nxt;
        end
    end

endmodule

// File: tb/tb_rnd_lfsr_source.sv
// Bench for rnd_lfsr_source: two instances (WARMUP=0 and WARMUP=16, RND_W=8) share
// the same stimulus. A sequence-level model predicts every output on every cycle;
// a few hand-derived literals pin the model itself.
module tb_rnd_lfsr_source;

    localparam int RW    = 8;
    localparam int NBITS = 4096;

    logic            clk        = 1'b0;
    logic            rst        = 1'b0;
    logic [31:0]     seed_in    = '0;
    logic            seed_valid = 1'b0;
    logic            rnd_ready  = 1'b0;
    logic [1:0]      d_sr;
    logic [1:0]      d_rv;
    logic [1:0]      d_sd;
    logic [1:0][RW-1:0] d_out;
    logic [1:0][1:0] d_st;

    int n_checks = 0;
    int n_err    = 0;

    // Clock
    initial forever #5 clk = ~clk;

    rnd_lfsr_source #(.RND_W(RW), .WARMUP(0)) u_w0 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(d_sr[0]), .rnd_out(d_out[0]), .rnd_valid(d_rv[0]),
        .rnd_ready(rnd_ready), .seeded(d_sd[0]), .dbg_state(d_st[0])
    );

    rnd_lfsr_source #(.RND_W(RW), .WARMUP(16)) u_w16 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(d_sr[1]), .rnd_out(d_out[1]), .rnd_valid(d_rv[1]),
        .rnd_ready(rnd_ready), .seeded(d_sd[1]), .dbg_state(d_st[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // The output stream is the LFSR bit sequence x[]: x[0..127] is the seed
    // (oldest bit first) and x[n] = x[n-128]^x[n-126]^x[n-101]^x[n-99].
    // Block b is x[128+b*RW .. 128+b*RW+RW-1], bit 0 first.
    bit          seq_bits [2][NBITS];
    int          m_wu     [2] = '{0, 16};
    bit          m_loading[2];
    int          m_beats  [2];
    int          m_wait   [2];
    int          m_idx    [2];
    bit          m_valid  [2];
    bit          m_seeded [2];
    logic [31:0] m_words  [2][4];

    function automatic logic [RW-1:0] blk(input int i, input int b);
        logic [RW-1:0] r;
        for (int k = 0; k < RW; k++) r[k] = seq_bits[i][128 + b*RW + k];
        return r;
    endfunction

    task automatic build_seq(input int i);
        logic [127:0] s0;
        s0 = {m_words[i][3], m_words[i][2], m_words[i][1], m_words[i][0]};
        if (s0 == '0) s0 = 128'd1;
        for (int j = 0; j < 128; j++) seq_bits[i][j] = s0[127-j];
        for (int j = 128; j < NBITS; j++)
            seq_bits[i][j] = seq_bits[i][j-128] ^ seq_bits[i][j-126] ^ seq_bits[i][j-101] ^ seq_bits[i][j-99];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_loading[i] = 1'b0;
            m_beats[i]   = 0;
            m_wait[i]    = 0;
            m_idx[i]     = 0;
            m_valid[i]   = 1'b0;
            m_seeded[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        for (int i = 0; i < 2; i++) begin
            acc = seed_valid && (m_wait[i] == 0);
            if (m_valid[i] && rnd_ready) m_idx[i]++;
            if (acc) begin
                if (!m_loading[i]) begin
                    m_words[i][0] = seed_in;
                    m_beats[i]    = 1;
                    m_loading[i]  = 1'b1;
                    m_valid[i]    = 1'b0;
                    m_seeded[i]   = 1'b0;
                end else begin
                    m_words[i][m_beats[i]] = seed_in;
                    m_beats[i]++;
                    if (m_beats[i] == 4) begin
                        m_loading[i] = 1'b0;
                        build_seq(i);
                        m_wait[i] = m_wu[i] + 1;
                    end
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_valid[i]  = 1'b1;
                    m_seeded[i] = 1'b1;
                    m_idx[i]    = m_wu[i];
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    // ---------------- compare (every cycle, away from the active edge) ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("seed_ready[%0d]", i), d_sr[i], (m_wait[i] == 0));
            check($sformatf("rnd_valid[%0d]", i), d_rv[i], m_valid[i]);
            check($sformatf("seeded[%0d]", i), d_sd[i], m_seeded[i]);
            if (m_valid[i]) check($sformatf("rnd_out[%0d]", i), d_out[i], blk(i, m_idx[i]));
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [31:0] v);
        seed_in    = v;
        seed_valid = 1'b1;
        @(posedge clk);
        #2;
        seed_valid = 1'b0;
    endtask

    task automatic send_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        send_beat(a);
        send_beat(b);
        send_beat(c);
        send_beat(d);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lows;
        int nz;
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset_out", d_out, '0);
        check("reset_valid", d_rv, 2'b00);
        check("reset_seeded", d_sd, 2'b00);
        check("reset_seed_ready", d_sr, 2'b11);
        @(posedge clk);
        #2 rst = 1'b0;

        // Seed 1 with WARMUP=0: first block 0x00 one edge after beat 3, block 12 is 0x14.
        rnd_ready = 1'b0;
        send_seed(32'h1, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        check("w0_first_valid", d_rv[0], 1'b1);
        check("w0_first_blk", d_out[0], 8'h00);
        check("model_blk12", blk(0, 12), 8'h14);
        rnd_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("w0_blk12", d_out[0], 8'h14);
        repeat (40) @(posedge clk);
        #2;

        // Reseed with a scrambled seed, ready held high: WARMUP=16 refuses seeds for 17 cycles.
        send_seed(32'h9e3779b9, 32'h7f4a7c15, 32'hf39cc060, 32'h5851f42d);
        lows = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (!d_sr[1]) lows++;
        end
        check("w16_ready_low_cycles", lows, 17);
        repeat (20) @(posedge clk);
        #2;

        // Back-pressure for 5 cycles: the presented block must hold.
        rnd_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 rnd_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        // Reseed from RUN while consuming.
        send_beat(32'h13579bdf);
        check("reseed_valid_drop", d_rv, 2'b00);
        check("reseed_seeded_drop", d_sd, 2'b00);
        send_beat(32'h2468ace0);
        send_beat(32'h0f1e2d3c);
        send_beat(32'h4b5a6978);
        repeat (30) @(posedge clk);
        #2;

        // All-zero seed behaves exactly like seed 1.
        rnd_ready = 1'b0;
        send_seed(32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        check("zero_first_valid", d_rv[0], 1'b1);
        check("zero_first_blk", d_out[0], 8'h00);
        rnd_ready = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("zero_blk12", d_out[0], 8'h14);
        nz = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d_rv[0] && d_out[0] != 8'h00) nz++;
        end
        check("zero_not_stuck", (nz > 0), 1'b1);
        @(posedge clk);
        #2;

        // Asynchronous reset in the middle of the WARMUP=16 warm-up.
        send_seed(32'hcafef00d, 32'h1, 32'h2, 32'h3);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", d_out, '0);
        check("async_rst_valid", d_rv, 2'b00);
        check("async_rst_seeded", d_sd, 2'b00);
        check("async_rst_seed_ready", d_sr, 2'b11);
        check("async_rst_state", d_st[1], 2'd0);
        #5 rst = 1'b0;
        @(posedge clk);
        #2;
        send_seed(32'hcafef00d, 32'h1, 32'h2, 32'h3);
        repeat (30) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rnd_lfsr_source.md
Name: rnd_lfsr_source

Overview:
- Seeded pseudo-random bit source feeding the `rnd` port of refresh and multiplication gadgets, e.g. the constant-latency refresh.
- Delivers `RND_W` fresh bits per accepted transfer from a 128-bit Fibonacci LFSR.
- Seeds are loaded over a 32-bit beat interface, followed by a discarded warm-up run.
- Guarantees that no random block is ever presented again after it has been consumed.

Parameters:
- RND_W, default 8: random bits per output block; legal range 1..64 (gadget's ref_n_rnd).
- WARMUP, default 16: LFSR steps discarded after seeding; legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- seed_in  input  32  seed word.
- seed_valid  input  1  seed word present.
- seed_ready  output  1  seed word can be accepted.
- rnd_out  output  RND_W  random block, bit 0 generated first.
- rnd_valid  output  1  rnd_out holds a fresh, unconsumed block.
- rnd_ready  input  1  consumer takes rnd_out this cycle.
- seeded  output  1  high in RUN only.

Behaviour:
- Single LFSR step on state s[127:0]:
  - Feedback bit f = s[127]^s[125]^s[100]^s[98].
  - s <= {s[126:0], f}.
  - One "block step" = RND_W single steps in one cycle (unrolled). The RND_W f bits, in generation order, form the block: first f goes to bit 0.
- Reset (asynchronous, any state):
  - state=IDLE, s=0, beat counter=0, warm-up counter=0.
  - rnd_out=0, rnd_valid=0, seeded=0, seed_ready=1.
- seed_ready: 1 in IDLE, LOAD and RUN; 0 in WARMUP.
- Seed acceptance: a seed beat is accepted when seed_valid && seed_ready.
- IDLE: accepted beat writes s[31:0] = seed_in, beat counter=1, go to LOAD.
- LOAD:
  - Accepted beat k (k = 1..3) writes s[32k+31:32k].
  - After beat 3 is written: if the full s would be all-zero, s is forced to 128'h1 (lock-up avoidance). Go to WARMUP with warm-up counter=0.
  - No timeout; gaps between beats are allowed.
- WARMUP:
  - On each edge: if warm-up counter < WARMUP, perform one block step, discard its bits, and increment the counter.
  - Otherwise, perform one block step, load rnd_out with the block, set rnd_valid=1 and seeded=1, go to RUN.
  - Latency: rnd_valid rises WARMUP+1 edges after the edge that accepted beat 3. With WARMUP=0 it rises on the next edge.
- RUN:
  - On rnd_valid && rnd_ready: one block step; rnd_out <= new block; rnd_valid stays 1. A new block is presented every cycle under continuous ready.
  - Without rnd_ready: s and rnd_out hold unchanged. The unconsumed block is not lost or regenerated.
- Reseed from RUN:
  - An accepted seed beat restarts loading: s[31:0] <= seed_in, beat counter=1, rnd_valid=0, seeded=0, go to LOAD.
  - If rnd_ready is high in the same cycle, the transfer of the current rnd_out still completes; that block is the last one of the old seed.
  - Upper s words keep old content until overwritten by beats 1..3.
- rnd_out after rnd_valid falls: holds its last value but is not valid. Consumers must qualify it with rnd_valid.
- Freshness: a block is consumed at most once. Hidden/visible state is never rewound except by reseed or reset.

Test Plan:
- RND_W=8, WARMUP=0, seed beats 0x00000001,0,0,0 -> rnd_valid rises 1 edge after beat 3; first rnd_out=0x00, LFSR s=128'h100; continuous ready then gives a stream matching a bit-serial reference model.
- Seed all four beats 0 -> stream identical to the seed-1 case (forced 128'h1); rnd_out never stuck at 0 over 200 blocks.
- WARMUP=16, random seed, rnd_ready held 1 -> seed_ready=0 for exactly 17 cycles, rnd_valid at edge 17; first block equals the 17th block of the reference model.
- RUN, drop rnd_ready for 5 cycles -> rnd_out and s unchanged for those cycles; the next accepted block is the reference successor; no block repeated or skipped.
- RUN, present seed beat with rnd_ready=1 -> the current block is counted as consumed; next cycle rnd_valid=0, seeded=0; after 3 more beats the stream restarts per the new seed.
- Assert rst mid-WARMUP (asynchronous, between edges) -> outputs 0 and seed_ready=1 immediately; state IDLE; a subsequent 4-beat load behaves like a first load.
